// File: rtl/apb_master_arbiter_if.sv
// APB bus between the bridge's arbitrating master and its one-hot selected slave banks.
interface apb_master_arbiter_if #(
    parameter int BANK_ADDR  = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic [BANK_ADDR-1:0]  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin two-requester APB master: one transfer at a time, bounded wait on pready,
// bad-bank requests answered with an error and no bus activity.
module apb_master_arbiter #(
    parameter int BANK_ADDR  = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int TIMEOUT    = 15
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  r0_req,
    input  logic                  r0_write,
    input  logic [BANK_ADDR-1:0]  r0_bank,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_done,
    output logic                  r0_err,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    input  logic                  r1_req,
    input  logic                  r1_write,
    input  logic [BANK_ADDR-1:0]  r1_bank,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_done,
    output logic                  r1_err,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    apb_master_arbiter_if.master  apb
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t                state_reg, state_next;
    logic                  grant_reg, grant_next;
    logic                  last_grant_reg, last_grant_next;
    logic                  write_reg, write_next;
    logic [BANK_ADDR-1:0]  bank_reg, bank_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic                  err_reg, err_next;
    logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
    logic [7:0]            wait_cnt_reg, wait_cnt_next;

    logic                  win;
    logic                  sel_write;
    logic [BANK_ADDR-1:0]  sel_bank;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    function automatic logic is_onehot(input logic [BANK_ADDR-1:0] b);
        return (b != '0) && ((b & (b - BANK_ADDR'(1))) == '0);
    endfunction

    // Under contention the requester not served last wins; otherwise whoever is asking.
    assign win       = (r0_req && r1_req) ? ~last_grant_reg : r1_req;
    assign sel_write = win ? r1_write : r0_write;
    assign sel_bank  = win ? r1_bank  : r0_bank;
    assign sel_addr  = win ? r1_addr  : r0_addr;
    assign sel_wdata = win ? r1_wdata : r0_wdata;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_reg      <= IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            write_reg      <= 1'b0;
            bank_reg       <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            err_reg        <= 1'b0;
            rdata_reg      <= '0;
            wait_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            write_reg      <= write_next;
            bank_reg       <= bank_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            err_reg        <= err_next;
            rdata_reg      <= rdata_next;
            wait_cnt_reg   <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        write_next      = write_reg;
        bank_next       = bank_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        err_next        = err_reg;
        rdata_next      = rdata_reg;
        wait_cnt_next   = wait_cnt_reg;
        case (state_reg)
            IDLE: begin
                wait_cnt_next = '0;
                if (r0_req || r1_req) begin
                    grant_next      = win;
                    last_grant_next = win;
                    write_next      = sel_write;
                    bank_next       = sel_bank;
                    addr_next       = sel_addr;
                    wdata_next      = sel_wdata;
                    if (is_onehot(sel_bank)) begin
                        err_next   = 1'b0;
                        state_next = SETUP;
                    end else begin
                        err_next   = 1'b1;
                        state_next = RESP;
                    end
                end
            end
            SETUP: state_next = ACCESS;
            ACCESS: begin
                // pready takes priority over an expiring wait counter
                if (apb.pready) begin
                    if (!write_reg) begin
                        rdata_next = apb.prdata;
                    end
                    state_next = RESP;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    err_next   = 1'b1;
                    state_next = RESP;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign apb.psel    = (state_reg == SETUP || state_reg == ACCESS) ? bank_reg : '0;
    assign apb.penable = (state_reg == ACCESS);
    assign apb.pwrite  = write_reg;
    assign apb.paddr   = addr_reg;
    assign apb.pwdata  = wdata_reg;

    assign r0_done  = (state_reg == RESP) && !grant_reg;
    assign r1_done  = (state_reg == RESP) &&  grant_reg;
    assign r0_err   = r0_done && err_reg;
    assign r1_err   = r1_done && err_reg;
    assign r0_rdata = rdata_reg;
    assign r1_rdata = rdata_reg;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: expected completions are queued at request time
// and matched against each done pulse, together with the bus activity seen for that transfer.
module tb_apb_master_arbiter;
    localparam int BA = 2;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int TO = 15;

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          r0_req = 1'b0, r0_write = 1'b0;
    logic [BA-1:0] r0_bank = '0;
    logic [AW-1:0] r0_addr = '0;
    logic [DW-1:0] r0_wdata = '0;
    logic          r0_done, r0_err;
    logic [DW-1:0] r0_rdata;
    logic          r1_req = 1'b0, r1_write = 1'b0;
    logic [BA-1:0] r1_bank = '0;
    logic [AW-1:0] r1_addr = '0;
    logic [DW-1:0] r1_wdata = '0;
    logic          r1_done, r1_err;
    logic [DW-1:0] r1_rdata;

    apb_master_arbiter_if #(.BANK_ADDR(BA), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) apb ();

    apb_master_arbiter #(.BANK_ADDR(BA), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .r0_req(r0_req), .r0_write(r0_write), .r0_bank(r0_bank), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_done(r0_done), .r0_err(r0_err), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_write(r1_write), .r1_bank(r1_bank), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_done(r1_done), .r1_err(r1_err), .r1_rdata(r1_rdata),
        .apb(apb)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        bit            id;
        bit            err;
        logic [DW-1:0] rdata;
        int            done_cyc;
        int            pen;
        int            setups;
        logic [BA-1:0] psel;
        logic [AW-1:0] addr;
        bit            wr;
        logic [DW-1:0] wdata;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model_rdata = '0;
    int            slave_wait = 0;

    // Bench-side expectation for one transfer; slave_wait < 0 means the slave never answers.
    function automatic exp_t build_exp(input bit id, input bit wr, input logic [BA-1:0] bank,
                                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                       input int swait, input logic [DW-1:0] prd, input int start);
        exp_t e;
        bit   good;
        good       = (bank == 2'b01) || (bank == 2'b10);
        e.id       = id;
        e.err      = !good || (swait < 0);
        e.pen      = !good ? 0 : ((swait < 0) ? TO : swait + 1);
        e.setups   = good ? 1 : 0;
        e.psel     = good ? bank : '0;
        e.done_cyc = start + (good ? 2 + e.pen : 1);
        e.addr     = addr;
        e.wr       = wr;
        e.wdata    = wdata;
        if (!e.err && !wr) model_rdata = prd;
        e.rdata    = model_rdata;
        return e;
    endfunction

    // Slave: answers pready after slave_wait ACCESS cycles.
    initial begin
        int acc_cnt;
        acc_cnt = 0;
        apb.pready = 1'b0;
        forever begin
            @(negedge pclk);
            if (apb.psel != '0 && apb.penable) begin
                apb.pready = (slave_wait >= 0) && (acc_cnt == slave_wait);
                acc_cnt++;
            end else begin
                apb.pready = 1'b0;
                acc_cnt = 0;
            end
        end
    end

    int            pen_cnt = 0, setup_cnt = 0;
    logic [BA-1:0] psel_or = '0;
    logic          pw_or = 1'b0;
    logic [AW-1:0] addr_cap = '0;
    logic [DW-1:0] wdata_cap = '0;

    task automatic handle_done(input bit id, input bit err, input logic [DW-1:0] rdata);
        exp_t e;
        $display("xfer r%0d err=%0d rdata=%02h cyc=%0d pen=%0d", id, err, rdata, cyc, pen_cnt);
        if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
            return;
        end
        e = sb.pop_front();
        check("grant_id", 32'(id), 32'(e.id));
        check("err", 32'(err), 32'(e.err));
        check("rdata", 32'(rdata), 32'(e.rdata));
        check("done_cyc", cyc, e.done_cyc);
        check("pen_cycles", pen_cnt, e.pen);
        check("setup_cycles", setup_cnt, e.setups);
        check("psel", 32'(psel_or), 32'(e.psel));
        if (e.setups != 0) begin
            check("paddr", 32'(addr_cap), 32'(e.addr));
            check("pwrite", 32'(pw_or), 32'(e.wr));
            if (e.wr) check("pwdata", 32'(wdata_cap), 32'(e.wdata));
        end
    endtask

    // Monitor: tallies bus activity per transfer and scores each done pulse.
    initial begin
        forever begin
            @(negedge pclk);
            if (!presetn || r0_done || r1_done) begin
                if (presetn && r0_done) handle_done(1'b0, r0_err, r0_rdata);
                if (presetn && r1_done) handle_done(1'b1, r1_err, r1_rdata);
                pen_cnt = 0; setup_cnt = 0; psel_or = '0; pw_or = 1'b0;
            end else if (apb.psel != '0) begin
                psel_or |= apb.psel;
                pw_or   |= apb.pwrite;
                if (apb.penable) begin
                    pen_cnt++;
                end else begin
                    setup_cnt++;
                    addr_cap  = apb.paddr;
                    wdata_cap = apb.pwdata;
                end
            end
        end
    end

    task automatic do_xfer(input bit id, input bit wr, input logic [BA-1:0] bank,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int swait, input logic [DW-1:0] prd);
        bit seen;
        @(posedge pclk); #1;
        slave_wait = swait;
        apb.prdata = prd;
        sb.push_back(build_exp(id, wr, bank, addr, wdata, swait, prd, cyc));
        if (id) begin
            r1_write = wr; r1_bank = bank; r1_addr = addr; r1_wdata = wdata; r1_req = 1'b1;
        end else begin
            r0_write = wr; r0_bank = bank; r0_addr = addr; r0_wdata = wdata; r0_req = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge pclk);
            seen = id ? r1_done : r0_done;
        end
        if (!seen) check("done_wait", 0, 1);
        r0_req = 1'b0;
        r1_req = 1'b0;
    endtask

    task automatic do_contention();
        int k, n0, n1;
        @(posedge pclk); #1;
        k = cyc;
        slave_wait = 0;
        r0_write = 1'b1; r0_bank = 2'b01; r0_addr = 3'h1; r0_wdata = 8'h11;
        r1_write = 1'b1; r1_bank = 2'b10; r1_addr = 3'h6; r1_wdata = 8'h66;
        sb.push_back(build_exp(1'b0, 1'b1, 2'b01, 3'h1, 8'h11, 0, 8'h00, k));
        sb.push_back(build_exp(1'b1, 1'b1, 2'b10, 3'h6, 8'h66, 0, 8'h00, k + 4));
        sb.push_back(build_exp(1'b0, 1'b1, 2'b01, 3'h1, 8'h11, 0, 8'h00, k + 8));
        sb.push_back(build_exp(1'b1, 1'b1, 2'b10, 3'h6, 8'h66, 0, 8'h00, k + 12));
        r0_req = 1'b1;
        r1_req = 1'b1;
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 60 && (r0_req || r1_req); i++) begin
            @(negedge pclk);
            if (r0_done) begin n0++; if (n0 == 2) r0_req = 1'b0; end
            if (r1_done) begin n1++; if (n1 == 2) r1_req = 1'b0; end
        end
        if (r0_req || r1_req) check("contention_wait", 0, 1);
        r0_req = 1'b0;
        r1_req = 1'b0;
    endtask

    initial begin
        bit seen;
        apb.prdata = '0;
        repeat (2) @(negedge pclk);
        check("rst_psel", 32'(apb.psel), 0);
        check("rst_penable", 32'(apb.penable), 0);
        check("rst_pwrite", 32'(apb.pwrite), 0);
        check("rst_paddr", 32'(apb.paddr), 0);
        check("rst_pwdata", 32'(apb.pwdata), 0);
        check("rst_r0_done", 32'(r0_done), 0);
        check("rst_r0_err", 32'(r0_err), 0);
        check("rst_r0_rdata", 32'(r0_rdata), 0);
        check("rst_r1_done", 32'(r1_done), 0);
        check("rst_r1_err", 32'(r1_err), 0);
        check("rst_r1_rdata", 32'(r1_rdata), 0);
        presetn = 1'b1;

        do_xfer(1'b0, 1'b1, 2'b01, 3'h5, 8'hA5, 1, 8'h00);   // write, one wait state
        do_xfer(1'b1, 1'b0, 2'b10, 3'h2, 8'h00, 0, 8'h3C);   // zero-wait read
        do_xfer(1'b0, 1'b0, 2'b01, 3'h3, 8'h00, -1, 8'h77);  // dead slave -> timeout
        do_xfer(1'b0, 1'b0, 2'b01, 3'h3, 8'h00, 14, 8'h77);  // pready in last ACCESS cycle
        do_xfer(1'b0, 1'b0, 2'b00, 3'h4, 8'h00, 0, 8'hEE);   // no bank selected
        do_xfer(1'b0, 1'b1, 2'b11, 3'h4, 8'h99, 0, 8'hEE);   // two banks selected

        // Reset in the middle of ACCESS drops the transfer without a done pulse.
        @(posedge pclk); #1;
        slave_wait = -1;
        r0_write = 1'b0; r0_bank = 2'b01; r0_addr = 3'h4; r0_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge pclk);
            seen = apb.penable;
        end
        check("reach_access", 32'(seen), 1);
        presetn = 1'b0;
        model_rdata = '0;
        #1;
        check("midrst_psel", 32'(apb.psel), 0);
        check("midrst_penable", 32'(apb.penable), 0);
        check("midrst_r0_done", 32'(r0_done), 0);
        check("midrst_rdata", 32'(r1_rdata), 32'(model_rdata));
        r0_req = 1'b0;
        repeat (3) @(negedge pclk);
        presetn = 1'b1;
        do_xfer(1'b1, 1'b0, 2'b10, 3'h2, 8'h00, 0, 8'h5A);

        // Contention straight out of reset.
        @(negedge pclk);
        presetn = 1'b0;
        model_rdata = '0;
        @(negedge pclk);
        presetn = 1'b1;
        do_contention();

        repeat (3) @(negedge pclk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Two-requester APB master for the GPIO expander's SPI-to-APB bridge. It shares one APB bus between requester 0 (SPI command decoder) and requester 1 (auxiliary/config engine) using round-robin arbitration. It sequences the APB SETUP/ACCESS phases toward `BANK_ADDR` one-hot-selected slave banks and returns read data or an error per transfer. A bounded wait on `pready` prevents a dead slave from hanging the bridge.

## Interface
- `BANK_ADDR`, 2, number of slave banks (width of `psel`)
- `DATA_WIDTH`, 8, APB data width
- `ADDR_WIDTH`, 3, APB address width
- `TIMEOUT`, 15, maximum ACCESS cycles waited for `pready` (1..255)

- `pclk` in 1: single clock, all logic on rising edge
- `presetn` in 1: reset, asynchronous, active-low
- `rN_req` in 1 (N=0,1): transfer request; held high with fields stable until `rN_done`
- `rN_write` in 1: 1 = write, 0 = read
- `rN_bank` in BANK_ADDR: one-hot target bank
- `rN_addr` in ADDR_WIDTH: register address
- `rN_wdata` in DATA_WIDTH: write data
- `rN_done` out 1: one-cycle completion pulse
- `rN_err` out 1: valid with `rN_done`; 1 = bad bank or timeout
- `rN_rdata` out DATA_WIDTH: read data, valid with `rN_done` on error-free reads
- `psel` out BANK_ADDR; `penable` out 1; `pwrite` out 1; `paddr` out ADDR_WIDTH; `pwdata` out DATA_WIDTH: APB master outputs
- `pready` in 1; `prdata` in DATA_WIDTH: APB slave response

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- **IDLE**
  - If any `rN_req` is high: grant one requester and latch its write/bank/addr/wdata into the transfer register.
  - Bank check: if the bank is exactly one-hot, go to SETUP. Otherwise set the error flag and go to RESP; no APB activity occurs.
- **Arbitration:** a single request wins. When both requesters are high, the one not served last wins. `last_grant` resets to 1, so r0 wins the first contention. `last_grant` updates on every grant.
- **SETUP:** `psel` = latched bank, `penable` = 0, `paddr`/`pwrite`/`pwdata` driven. Next state is ACCESS.
- **ACCESS:** `penable` = 1, other APB outputs unchanged. The wait counter starts at 0 and increments each ACCESS cycle with `pready` = 0.
  - `pready` = 1: capture `prdata` (reads only), then go to RESP.
  - Counter reaches `TIMEOUT` with `pready` = 0: set the error flag, then go to RESP.
  - `pready` in the same cycle as the counter reaching `TIMEOUT`: `pready` wins and no error is flagged.
- **RESP:** `psel` = 0, `penable` = 0. Pulse `done` and `err` of the granted requester for exactly this cycle, then go to IDLE.
- **Shared read data:** both `rN_rdata` ports come from one read-data register.
  - It updates only on a successful read.
  - Writes and errors leave it unchanged.
- A requester may keep `req` high after `done`. It is re-arbitrated in the following IDLE cycle as a new transfer.
- A requester dropping `req` mid-transfer has no effect; the transfer completes and `done` still pulses.

## Timing
- **Reset values:** all outputs 0, including `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `rN_done`, `rN_err`, `rN_rdata`. Internal state: FSM = IDLE, wait counter = 0, `last_grant` = 1.
- **Reset mid-transfer:** outputs return to reset values immediately (asynchronous). The transfer is dropped and no `done` is produced.
- **Good-bank latency:** with `req` sampled in IDLE at edge T, SETUP is T+1 and ACCESS is T+2.
  - Zero-wait slave (`pready` at T+2): RESP/`done` at T+3.
  - Each wait cycle adds 1.
- **Bad-bank latency:** `done` with `err` = 1 at T+1.
- **Timeout latency:** `done` with `err` = 1 at T+2+`TIMEOUT`.
- **Back-to-back:** the next transfer's SETUP is no earlier than RESP+2, so there is always at least one IDLE cycle with `psel` = 0 between transfers.
- All outputs are registered; none depend combinationally on `pready`.

## Test plan
- **r0 write:** bank=01, addr=3'h5, wdata=8'hA5; slave asserts `pready` the cycle after `penable` → `psel`=01 / `penable`=0 for 1 cycle, then `penable`=1 for 2 cycles. `r0_done`=1, `r0_err`=0 exactly 4 cycles after the request is sampled.
- **r1 read:** bank=10, addr=3'h2, `prdata`=8'h3C, zero-wait slave → `r1_done` at T+3, `r1_rdata`=8'h3C, `r1_err`=0, `pwrite`=0 throughout.
- **Contention:** r0 and r1 request simultaneously from reset, both held high for 4 transfers → grant order r0, r1, r0, r1, with one IDLE cycle between each.
- **Bad bank:** r0 bank=00, then bank=11 → `r0_done`=1 with `r0_err`=1 at T+1; `psel` never leaves 0.
- **Timeout:** slave holds `pready`=0 → `penable` high for 15 cycles, `r0_done` with `r0_err`=1 at T+17, `rdata` unchanged. Repeat with `pready` asserted in the 15th ACCESS cycle → `err`=0.
- **Reset mid-ACCESS:** assert `presetn`=0 during ACCESS → `psel`/`penable` drop to 0 immediately and no `done` is produced. After release, a new r1 read completes normally.
